// File: rtl/seqdet_pkg.sv
// ---------------------------------------------------------------------------
// seqdet_pkg
// Shared types and helpers for the programmable sequence detector.
//   seqdet_state_t : detector FSM state (IDLE / FILL / DETECT)
//   seqdet_len_w() : width needed to hold a pattern length 0..PAT_W
// ---------------------------------------------------------------------------
package seqdet_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        DETECT = 2'd2
    } seqdet_state_t;

    function automatic int seqdet_len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// ---------------------------------------------------------------------------
// seqdet_sat_counter
// Saturating up-counter for detected matches. Clear has priority over
// increment; the count sticks at all-ones once reached.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (count -> 0)
//   inc     : count one event this cycle
//   clr     : synchronous clear, wins over inc
//   count   : registered count value
// ---------------------------------------------------------------------------
module seqdet_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (val == CNT_MAX) ? CNT_MAX : val + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// ---------------------------------------------------------------------------
// seq_detect_prog
// Runtime-programmable serial bit-pattern detector. A pattern of 1..PAT_W
// bits is loaded with cfg_load and searched for in the qualified serial
// stream, with or without overlapping matches.
//
// Build option: define SEQDET_COUNT_EN to include the saturating match
// counter (match_count / count_clr). Without it match_count is tied to 0
// and count_clr is ignored.
//
// Ports:
//   clk          : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   in_valid     : in_bit is sampled this cycle
//   in_bit       : serial data bit
//   cfg_load     : latch cfg_pattern / cfg_len / cfg_overlap (wins over in_valid)
//   cfg_pattern  : pattern, oldest bit at cfg_len-1, newest at bit 0
//   cfg_len      : pattern length, legal range 1..PAT_W
//   cfg_overlap  : 1 = overlapping matches allowed
//   count_clr    : synchronous clear of match_count
//   match        : registered one-cycle pulse per detected pattern
//   match_count  : saturating number of matches
//   busy         : a legal configuration is held
// ---------------------------------------------------------------------------
module seq_detect_prog
    import seqdet_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = seqdet_len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             count_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

    seqdet_state_t    state;
    logic [PAT_W-1:0] pat_r;
    logic [LEN_W-1:0] len_r;
    logic             ovl_r;
    logic [PAT_W-1:0] hist;
    logic [LEN_W-1:0] fill;

    logic [PAT_W-1:0] hist_next;
    logic [LEN_W-1:0] fill_next;
    logic [PAT_W-1:0] len_mask;
    logic             cfg_legal;
    logic             accept;
    logic             hit;
    logic             unused_hist_msb;

    assign cfg_legal = (cfg_len != '0) && (cfg_len <= MAX_LEN);

    // No bits are taken without a legal configuration, and a load in the
    // same cycle discards the incoming bit.
    assign accept    = in_valid && !cfg_load && (state != IDLE);

    // The oldest history bit simply falls off the end of the shift.
    assign hist_next       = {hist[PAT_W-2:0], in_bit};
    assign unused_hist_msb = hist[PAT_W-1];

    // fill never exceeds len_r, so fill+1 cannot overflow LEN_W here.
    assign fill_next = (fill >= len_r) ? len_r : fill + LEN_W'(1);

    // Only the low len_r bits take part in the comparison.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (LEN_W'(i) < len_r);
        end
    end

    assign hit = accept && (fill_next == len_r) &&
                 (((hist_next ^ pat_r) & len_mask) == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            pat_r <= '0;
            len_r <= '0;
            ovl_r <= 1'b0;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (cfg_load) begin
            pat_r <= cfg_pattern;
            len_r <= cfg_len;
            ovl_r <= cfg_overlap;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
            state <= cfg_legal ? FILL : IDLE;
            busy  <= cfg_legal;
        end else if (accept) begin
            hist  <= hist_next;
            match <= hit;
            if (hit && !ovl_r) begin
                // Non-overlapping: the completing bit starts nothing new.
                fill  <= '0;
                state <= (len_r == LEN_W'(1)) ? DETECT : FILL;
            end else begin
                fill  <= fill_next;
                state <= (fill_next == len_r) ? DETECT : FILL;
            end
        end else begin
            match <= 1'b0;
        end
    end

`ifdef SEQDET_COUNT_EN
    // Counts the registered match pulse, so the count moves one edge after
    // the completing bit, in the cycle match is high.
    seqdet_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (match),
        .clr     (count_clr),
        .count   (match_count)
    );
`else
    logic unused_count_clr;
    assign unused_count_clr = count_clr;
    assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
module tb_seq_detect_prog;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = 4;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_bit;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             count_clr;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             busy;

    seq_detect_prog #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .match       (match),
        .match_count (match_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: configuration plus the list of usable bits seen.
    bit       m_busy;
    int       m_len;
    bit [7:0] m_pat;
    bit       m_ovl;
    bit       q[$];
    bit       exp_match;
    int       exp_cnt;
    int       n_hits;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_len = 0; m_pat = 0; m_ovl = 0;
        q.delete();
        exp_match = 0;
        exp_cnt = 0;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_edge(input bit ld, input bit [7:0] pat, input int len,
                              input bit ovl, input bit v, input bit b, input bit clr);
        int  val;
        int  want;
        bit  h;
`ifdef SEQDET_COUNT_EN
        if (clr) exp_cnt = 0;
        else if (exp_match && exp_cnt < 3) exp_cnt = exp_cnt + 1;
`else
        exp_cnt = 0;
`endif
        if (ld) begin
            m_pat = pat; m_len = len; m_ovl = ovl;
            m_busy = (len >= 1 && len <= PAT_W);
            q.delete();
            exp_match = 0;
        end else if (v && m_busy) begin
            q.push_back(b);
            if (q.size() > m_len) void'(q.pop_front());
            h = 0;
            if (q.size() == m_len) begin
                val = 0;
                foreach (q[i]) val = (val << 1) | int'(q[i]);
                want = int'(m_pat) & ((1 << m_len) - 1);
                h = (val == want);
            end
            exp_match = h;
            if (h) n_hits++;
            if (h && !m_ovl) q.delete();
        end else begin
            exp_match = 0;
        end
    endtask

    task automatic tick(input bit ld, input bit [7:0] pat, input int len,
                        input bit ovl, input bit v, input bit b, input bit clr);
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        in_valid    = v;
        in_bit      = b;
        count_clr   = clr;
        @(posedge clk);
        model_edge(ld, pat, len, ovl, v, b, clr);
        #1;
        check_val("match", {31'b0, match}, {31'b0, exp_match});
        check_val("busy", {31'b0, busy}, {31'b0, m_busy});
        check_val("match_count", {30'b0, match_count}, exp_cnt);
    endtask

    task automatic load(input bit [7:0] pat, input int len, input bit ovl);
        tick(1, pat, len, ovl, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) tick(0, 0, 0, 0, 1, (s[i] == "1"), 0);
    endtask

    // Reset asserted and released between clock edges.
    task automatic async_reset();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_match", {31'b0, match}, 0);
        check_val("rst_busy", {31'b0, busy}, 0);
        check_val("rst_count", {30'b0, match_count}, 0);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int hits_before;

    initial begin
        reset_n = 1'b0;
        cfg_load = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
        in_valid = 0; in_bit = 0; count_clr = 0;
        n_hits = 0;
        model_reset();
        #12;
        check_val("reset_match", {31'b0, match}, 0);
        check_val("reset_busy", {31'b0, busy}, 0);
        check_val("reset_count", {30'b0, match_count}, 0);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // No configuration yet: nothing matches.
        feed("1111");

        // Overlap mode.
        load(8'b10101, 5, 1);
        hits_before = n_hits;
        feed("1010101");
        idle(1);
        check_val("ovl_hits", n_hits - hits_before, 2);

        // Non-overlap mode.
        load(8'b10101, 5, 0);
        hits_before = n_hits;
        feed("1010110101");
        idle(1);
        check_val("novl_hits_a", n_hits - hits_before, 2);
        load(8'b10101, 5, 0);
        hits_before = n_hits;
        feed("1010101");
        idle(1);
        check_val("novl_hits_b", n_hits - hits_before, 1);

        // Gaps between valid bits.
        load(8'b0110, 4, 0);
        hits_before = n_hits;
        feed("0"); idle(3); feed("1"); idle(3); feed("1"); idle(3); feed("0"); idle(2);
        check_val("gap_hits", n_hits - hits_before, 1);

        // Single-bit pattern: back-to-back matches, counter saturation and
        // clear-wins-over-increment.
        load(8'b1, 1, 0);
        feed("11111");
        idle(2);
        feed("1");
        tick(0, 0, 0, 0, 1, 1, 1);
        tick(0, 0, 0, 0, 0, 0, 0);

        // Illegal lengths.
        load(8'hFF, 0, 1);
        feed("11111111");
        load(8'h00, 9, 1);
        feed("00000000");

        // Load concurrent with a valid bit: the bit is discarded.
        tick(1, 8'b11, 2, 0, 1, 1, 0);
        feed("1");
        tick(0, 0, 0, 0, 1, 1, 0);

        // Reload mid-pattern.
        load(8'b10101, 5, 0);
        feed("101");
        load(8'b10101, 5, 0);
        feed("01");
        feed("10101");

        // Reset mid-stream.
        load(8'b1011, 4, 1);
        feed("101");
        async_reset();
        feed("1");
        feed("1011");
        load(8'b1011, 4, 1);
        feed("1011011");

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit       ld;
            bit [7:0] p;
            int       l;
            ld = ($urandom_range(0, 39) == 0);
            p  = 8'($urandom);
            l  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 4));
            if (l <= 4) p = p & 8'h0F;
            tick(ld, p, l, 1'($urandom), ($urandom_range(0, 9) < 7), 1'($urandom),
                 ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
